// File: rtl/tcdm_rr_port_arbiter.sv
// Round-robin arbiter sharing one TCDM master port between N_REQ requesters; grant is combinational.
// Granted IDs queue in order so responses route back; at MAX_OUTST in flight, requests are held off.
module tcdm_rr_port_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   add_i,
  input  logic [N_REQ-1:0]              wen_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              r_valid_o,
  output logic [N_REQ*DATA_WIDTH-1:0]   r_rdata_o,
  output logic                          tcdm_req_o,
  output logic [ADDR_WIDTH-1:0]         tcdm_add_o,
  output logic                          tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0]       tcdm_be_o,
  output logic [DATA_WIDTH-1:0]         tcdm_wdata_o,
  input  logic                          tcdm_gnt_i,
  input  logic                          tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]         tcdm_r_rdata_i,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ID_W     = $clog2(N_REQ);
  localparam int unsigned PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;
  logic [ID_W-1:0]  id_fifo_q [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  // Scan rr_ptr, rr_ptr+1, ... and take the first active requester.
  always_comb begin
    int unsigned k;
    logic [ID_W-1:0] idx;
    win_vld = 1'b0;
    win_id  = '0;
    k       = 0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      idx = ID_W'(k);
      if (!win_vld && req_i[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
  assign fifo_empty = (cnt_q == '0);
  assign tcdm_req_o = rst_ni & win_vld & ~fifo_full;
  assign push       = tcdm_req_o & tcdm_gnt_i;
  assign pop        = rst_ni & tcdm_r_valid_i & ~fifo_empty;

  always_comb begin
    tcdm_add_o   = '0;
    tcdm_wen_o   = 1'b0;
    tcdm_be_o    = '0;
    tcdm_wdata_o = '0;
    if (rst_ni && win_vld) begin
      tcdm_add_o   = add_i[win_id*ADDR_WIDTH +: ADDR_WIDTH];
      tcdm_wen_o   = wen_i[win_id];
      tcdm_be_o    = be_i[win_id*BE_WIDTH +: BE_WIDTH];
      tcdm_wdata_o = wdata_i[win_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (push) gnt_o[win_id] = 1'b1;
    if (pop)  r_valid_o[id_fifo_q[rd_ptr_q]] = 1'b1;
  end

  assign r_rdata_o = rst_ni ? {N_REQ{tcdm_r_rdata_i}} : '0;
  assign busy_o    = ~fifo_empty;
  assign err_o     = err_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      rr_ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A response with nothing outstanding is a protocol violation and stays flagged.
    err_d = err_q | (tcdm_r_valid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) id_fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) id_fifo_q[wr_ptr_q] <= win_id;
    end
  end

endmodule

// File: tb/tb_tcdm_rr_port_arbiter.sv
// Bench for tcdm_rr_port_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_tcdm_rr_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_i = '0;
  logic [N*AW-1:0]   add_i = '0;
  logic [N-1:0]      wen_i = '0;
  logic [N*DW/8-1:0] be_i = '0;
  logic [N*DW-1:0]   wdata_i = '0;
  logic [N-1:0]      gnt_o, r_valid_o;
  logic [N*DW-1:0]   r_rdata_o;
  logic              tcdm_req_o, tcdm_wen_o;
  logic [AW-1:0]     tcdm_add_o;
  logic [DW/8-1:0]   tcdm_be_o;
  logic [DW-1:0]     tcdm_wdata_o;
  logic              tcdm_gnt_i = 1'b0, tcdm_r_valid_i = 1'b0;
  logic [DW-1:0]     tcdm_r_rdata_i = '0;
  logic              busy_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: in-flight IDs, round-robin start, sticky error.
  int mq[$];
  int m_rr = 0;
  bit m_err = 1'b0;

  tcdm_rr_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o),
    .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_rdata_i(tcdm_r_rdata_i), .busy_o(busy_o), .err_o(err_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Inputs change on the falling edge; model compare at +2, literal checks at +3.
  always @(negedge clk) begin
    int w;
    bit any, full, hs, pop;
    logic [N-1:0] e_gnt, e_rv;
    logic [AW-1:0] e_add;
    logic [DW-1:0] e_wd;
    logic [DW/8-1:0] e_be;
    logic e_wen;
    #2;
    if (!rst_n) begin
      chk("rst_gnt", gnt_o, 0);
      chk("rst_rvalid", r_valid_o, 0);
      chk("rst_rdata", r_rdata_o, 0);
      chk("rst_req", tcdm_req_o, 0);
      chk("rst_add", tcdm_add_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      mq.delete();
      m_rr = 0;
      m_err = 1'b0;
    end else begin
      any = 1'b0; w = 0;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_rr + i) % N;
        if (!any && req_i[j]) begin any = 1'b1; w = j; end
      end
      full = (mq.size() == MO);
      hs   = any && !full && tcdm_gnt_i;
      pop  = tcdm_r_valid_i && (mq.size() > 0);
      e_gnt = '0; e_rv = '0;
      if (hs)  e_gnt[w] = 1'b1;
      if (pop) e_rv[mq[0]] = 1'b1;
      e_add = any ? add_i[w*AW +: AW] : '0;
      e_wd  = any ? wdata_i[w*DW +: DW] : '0;
      e_be  = any ? be_i[w*(DW/8) +: DW/8] : '0;
      e_wen = any ? wen_i[w] : 1'b0;
      chk("req", tcdm_req_o, any && !full);
      chk("gnt", gnt_o, e_gnt);
      chk("rvalid", r_valid_o, e_rv);
      chk("rdata", r_rdata_o, {N{tcdm_r_rdata_i}});
      chk("add", tcdm_add_o, e_add);
      chk("wdata", tcdm_wdata_o, e_wd);
      chk("be", tcdm_be_o, e_be);
      chk("wen", tcdm_wen_o, e_wen);
      chk("busy", busy_o, mq.size() != 0);
      chk("err", err_o, m_err);
      if (tcdm_r_valid_i && mq.size() == 0) m_err = 1'b1;
      if (pop) void'(mq.pop_front());
      if (hs) begin mq.push_back(w); m_rr = (w + 1) % N; end
    end
  end

  task automatic cyc(input logic rst, input logic [N-1:0] req, input logic gnt,
                     input logic rv, input logic [DW-1:0] rd);
    @(negedge clk);
    rst_n = rst; req_i = req; tcdm_gnt_i = gnt; tcdm_r_valid_i = rv; tcdm_r_rdata_i = rd;
    #3;
  endtask

  initial begin
    logic [N-1:0] b_gnt [6];
    logic [N-1:0] c_gnt [3];
    b_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    c_gnt = '{4'b1000, 4'b0010, 4'b1000};
    for (int k = 0; k < N; k++) begin
      add_i[k*AW +: AW]   = 32'hAD00_0000 + k;
      wdata_i[k*DW +: DW] = 32'hDA7A_0000 + k;
    end
    be_i = '1;

    // Reset with everything asserted: outputs must stay quiet.
    cyc(0, 4'hF, 1, 1, 32'hFFFF_FFFF);
    chk("lit_rst_gnt", gnt_o, 0);
    chk("lit_rst_req", tcdm_req_o, 0);
    cyc(0, 4'hF, 1, 1, 32'hFFFF_FFFF);

    // All four requesting, one-cycle responses.
    for (int k = 0; k < 6; k++) begin
      cyc(1, 4'hF, 1, k > 0, 32'hD000_0000 + k);
      chk("lit_all_gnt", gnt_o, b_gnt[k]);
      if (k > 0) chk("lit_all_rv", r_valid_o, b_gnt[k-1]);
    end
    cyc(1, 4'h0, 0, 1, 32'h1234_5678);
    chk("lit_all_rv_last", r_valid_o, 4'b0010);
    chk("lit_all_rdata", r_rdata_o, {N{32'h1234_5678}});
    cyc(1, 4'h0, 0, 0, 0);
    chk("lit_idle_busy", busy_o, 0);

    // req 1010 starting at rr_ptr=2.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 4'b1010, 1, 0, 0);
      chk("lit_1010_gnt", gnt_o, c_gnt[k]);
      if (k == 0) chk("lit_1010_add", tcdm_add_o, 32'hAD00_0003);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1, 4'h0, 0, 1, 32'h5555_0000 + k);
      chk("lit_1010_rv", r_valid_o, c_gnt[k]);
    end

    // Fill the FIFO with requester 2, then release one slot.
    for (int k = 0; k < 4; k++) begin
      cyc(1, 4'b0100, 1, 0, 0);
      chk("lit_fill_gnt", gnt_o, 4'b0100);
    end
    cyc(1, 4'b0100, 1, 0, 0);
    chk("lit_full_req", tcdm_req_o, 0);
    chk("lit_full_busy", busy_o, 1);
    cyc(1, 4'b0100, 1, 1, 32'h0BAD_F00D);
    chk("lit_full_pop_rv", r_valid_o, 4'b0100);
    chk("lit_full_pop_req", tcdm_req_o, 0);
    cyc(1, 4'b0100, 1, 0, 0);
    chk("lit_resume_gnt", gnt_o, 4'b0100);
    for (int k = 0; k < 4; k++) cyc(1, 4'h0, 0, 1, 32'h0000_1000 + k);

    // Master stalls: no grant, then grant goes to requester 0 from rr_ptr=3.
    for (int k = 0; k < 5; k++) begin
      cyc(1, 4'b0011, 0, 0, 0);
      chk("lit_stall_gnt", gnt_o, 0);
      chk("lit_stall_busy", busy_o, 0);
    end
    cyc(1, 4'b0011, 1, 0, 0);
    chk("lit_stall_then_gnt", gnt_o, 4'b0001);
    cyc(1, 4'h0, 0, 1, 32'hCAFE_0000);

    // Spurious response sets the sticky error.
    cyc(1, 4'h0, 0, 1, 32'hEEEE_EEEE);
    chk("lit_spur_rv", r_valid_o, 0);
    cyc(1, 4'h0, 0, 0, 0);
    chk("lit_spur_err", err_o, 1);
    cyc(0, 4'h0, 0, 0, 0);
    cyc(1, 4'h0, 0, 0, 0);
    chk("lit_err_cleared", err_o, 0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      req_i = $urandom_range(0, 3) == 0 ? '0 : N'($urandom);
      tcdm_gnt_i = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0) tcdm_r_valid_i = $urandom_range(0, 1);
      else               tcdm_r_valid_i = ($urandom_range(0, 39) == 0);
      tcdm_r_rdata_i = $urandom;
      wen_i = N'($urandom);
      be_i = (N*DW/8)'($urandom);
      for (int k = 0; k < N; k++) begin
        add_i[k*AW +: AW]   = $urandom;
        wdata_i[k*DW +: DW] = $urandom;
      end
    end
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
